// File: rtl/split_pkg.sv
// -----------------------------------------------------------------------------
// split_pkg
// Shared definitions for the split stimulus generator: run-state encoding,
// default geometry of the candidate word and witness buffer, the width of the
// hit counter, and a saturating-increment helper for that counter.
// -----------------------------------------------------------------------------
package split_pkg;

    // Run state of the enumeration engine
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEF_W     = 16;
    localparam int DEF_DEPTH = 4;
    localparam int HIT_W     = 16;

    // Increment the hit counter, sticking at all-ones instead of wrapping
    function automatic logic [HIT_W-1:0] hit_sat_inc(input logic [HIT_W-1:0] v);
        logic [HIT_W-1:0] r;
        if (v == {HIT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(HIT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/split_wit_fifo.sv
// -----------------------------------------------------------------------------
// split_wit_fifo
// Synchronous FIFO holding witnesses (satisfying candidates) until the
// downstream consumer takes them. A push into a full FIFO is accepted when a
// pop happens on the same edge, so a full FIFO streams without losing data.
//
// Ports
//   clk_i    clock, rising edge
//   rst_i    synchronous active-high reset, empties the FIFO
//   push_i   write data_i this cycle
//   data_i   W-bit word to write
//   pop_i    consumer takes data_o this cycle
//   data_o   oldest stored word (valid when empty_o is low)
//   full_o   DEPTH words stored
//   empty_o  no words stored
// -----------------------------------------------------------------------------
module split_wit_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   cnt_q;
    logic          pop_ok_s;
    logic          push_ok_s;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == (AW+1)'(0));
    assign data_o  = mem_q[rd_q];

    // A full FIFO still takes a push when the head leaves on the same edge
    assign pop_ok_s  = pop_i & ~empty_o;
    assign push_ok_s = push_i & (~full_o | pop_ok_s);

    // Pointer and occupancy update; DEPTH is a power of two so pointers wrap
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= AW'(0);
            rd_q  <= AW'(0);
            cnt_q <= (AW+1)'(0);
        end else begin
            if (push_ok_s) begin
                wr_q <= wr_q + AW'(1);
            end
            if (pop_ok_s) begin
                rd_q <= rd_q + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage array; contents need no reset because occupancy gates reads
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/split_stim_gen.sv
// -----------------------------------------------------------------------------
// split_stim_gen
// Enumerates candidate assignments lo..hi (inclusive), one per cycle, towards
// an external combinational constraint checker. Candidates the checker marks
// satisfying are queued as witnesses; a full witness buffer stalls the sweep.
// A run ends after hi is accepted or after max_hits witnesses (0 = no limit).
//
// Ports
//   clk_i, rst_i            clock and synchronous active-high reset
//   start_i                 begin a run (honoured in IDLE or DONE only)
//   lo_i, hi_i, max_hits_i  run bounds and hit limit, captured at start
//   cand_o, cand_valid_o    candidate presented to the checker
//   sat_i                   checker verdict for cand_o, same cycle
//   wit_data_o, wit_valid_o, wit_ready_i   witness stream (valid/ready)
//   busy_o, done_o, hit_count_o            run status
// -----------------------------------------------------------------------------
module split_stim_gen
    import split_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [W-1:0]     lo_i,
    input  logic [W-1:0]     hi_i,
    input  logic [7:0]       max_hits_i,
    output logic [W-1:0]     cand_o,
    output logic             cand_valid_o,
    input  logic             sat_i,
    output logic [W-1:0]     wit_data_o,
    output logic             wit_valid_o,
    input  logic             wit_ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [HIT_W-1:0] hit_count_o
);

    state_e           state_q;
    state_e           state_d;
    logic [W-1:0]     cand_q;
    logic [W-1:0]     cand_d;
    logic [W-1:0]     hi_q;
    logic [W-1:0]     hi_d;
    logic [7:0]       maxh_q;
    logic [7:0]       maxh_d;
    logic [HIT_W-1:0] hit_q;
    logic [HIT_W-1:0] hit_d;

    logic             run_s;
    logic             start_acc_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             pop_s;
    logic             can_push_s;
    logic             push_s;
    logic             accept_s;
    logic             last_s;
    logic             limit_s;
    logic             advance_s;
    logic [HIT_W-1:0] hit_inc_s;

    assign run_s       = (state_q == ST_RUN);
    assign start_acc_s = start_i & ((state_q == ST_IDLE) | (state_q == ST_DONE));

    assign pop_s       = ~fifo_empty_s & wit_ready_i;
    assign can_push_s  = ~fifo_full_s | pop_s;
    assign push_s      = run_s & sat_i & can_push_s;
    // A non-satisfying candidate never needs buffer space, so it never stalls
    assign accept_s    = run_s & (~sat_i | can_push_s);

    assign hit_inc_s   = hit_sat_inc(hit_q);
    assign last_s      = (cand_q == hi_q);
    assign limit_s     = push_s & (maxh_q != 8'd0) &
                         (hit_inc_s == {{(HIT_W-8){1'b0}}, maxh_q});
    // cand only moves when below hi, so an all-ones hi cannot wrap it to 0
    assign advance_s   = accept_s & ~last_s & ~limit_s;

    split_wit_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_wit_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_s),
        .data_i  (cand_q),
        .pop_i   (pop_s),
        .data_o  (wit_data_o),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an empty range (lo > hi) finishes immediately
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    if (lo_i > hi_i) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (accept_s && (last_s || limit_s)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the state register
    always_comb begin
        cand_valid_o = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        case (state_q)
            ST_RUN: begin
                cand_valid_o = 1'b1;
                busy_o       = 1'b1;
            end
            ST_DONE: begin
                done_o = 1'b1;
            end
            default: begin
                cand_valid_o = 1'b0;
                busy_o       = 1'b0;
                done_o       = 1'b0;
            end
        endcase
    end

    // Datapath next values: capture on start, count pushes, step candidate
    always_comb begin
        cand_d = cand_q;
        hi_d   = hi_q;
        maxh_d = maxh_q;
        hit_d  = hit_q;
        if (start_acc_s) begin
            cand_d = lo_i;
            hi_d   = hi_i;
            maxh_d = max_hits_i;
            hit_d  = {HIT_W{1'b0}};
        end else begin
            if (push_s) begin
                hit_d = hit_inc_s;
            end else begin
                hit_d = hit_q;
            end
            if (advance_s) begin
                cand_d = cand_q + W'(1);
            end else begin
                cand_d = cand_q;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cand_q <= {W{1'b0}};
            hi_q   <= {W{1'b0}};
            maxh_q <= 8'd0;
            hit_q  <= {HIT_W{1'b0}};
        end else begin
            cand_q <= cand_d;
            hi_q   <= hi_d;
            maxh_q <= maxh_d;
            hit_q  <= hit_d;
        end
    end

    assign cand_o      = cand_q;
    assign wit_valid_o = ~fifo_empty_s;
    assign hit_count_o = hit_q;

endmodule

// File: tb/tb_split_stim_gen.sv
module tb_split_stim_gen;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [15:0] lo_i;
    logic [15:0] hi_i;
    logic [7:0]  max_hits_i;
    logic [15:0] cand_o;
    logic        cand_valid_o;
    logic        sat_i;
    logic [15:0] wit_data_o;
    logic        wit_valid_o;
    logic        wit_ready_i;
    logic        busy_o;
    logic        done_o;
    logic [15:0] hit_count_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          sat_mode = 0;
    logic [15:0] seed     = 16'h0000;

    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];

    always #5 clk_i = ~clk_i;

    split_stim_gen #(.W(16), .DEPTH(4)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .lo_i         (lo_i),
        .hi_i         (hi_i),
        .max_hits_i   (max_hits_i),
        .cand_o       (cand_o),
        .cand_valid_o (cand_valid_o),
        .sat_i        (sat_i),
        .wit_data_o   (wit_data_o),
        .wit_valid_o  (wit_valid_o),
        .wit_ready_i  (wit_ready_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .hit_count_o  (hit_count_o)
    );

    // Constraint checker stand-in: combinational verdict on the live candidate
    assign sat_i = cand_valid_o &
                   ((sat_mode == 0) ? (cand_o[1:0] == 2'b00) :
                    (sat_mode == 1) ? 1'b1 :
                    ((((cand_o ^ seed) % 16'd3)) == 16'd0));

    // Witness collector: a handshake seen mid-cycle completes on the next edge
    always @(negedge clk_i) begin
        if (!rst_i && wit_valid_o && wit_ready_i) got_q.push_back(wit_data_o);
    end

    // Reference: the ordered satisfying values in [lo,hi], cut at the hit limit
    function automatic bit ref_sat(int v);
        if (sat_mode == 0) return (v % 4) == 0;
        if (sat_mode == 1) return 1'b1;
        return ((v ^ int'(seed)) % 3) == 0;
    endfunction

    task automatic build_expected(input int lo, input int hi, input int mx);
        exp_q.delete();
        for (int v = lo; v <= hi; v++) begin
            if (ref_sat(v)) exp_q.push_back(16'(v));
            if (mx != 0 && exp_q.size() == mx) break;
        end
    endtask

    task automatic start_run(input logic [15:0] lo, input logic [15:0] hi, input logic [7:0] mx);
        @(posedge clk_i); #1;
        lo_i = lo; hi_i = hi; max_hits_i = mx; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    // Advance until done and drained; reports the first cycle done was seen
    task automatic wait_finish(input int cyc0, input bit rnd_ready,
                               output int done_cyc, output bit timed_out);
        int cyc;
        cyc = cyc0; done_cyc = 0; timed_out = 1'b0;
        while (!(done_o && !wit_valid_o)) begin
            if (done_o && done_cyc == 0) done_cyc = cyc;
            if (cyc > 600) begin timed_out = 1'b1; break; end
            if (rnd_ready) wit_ready_i = 1'($urandom);
            @(posedge clk_i); #1;
            cyc++;
        end
        if (done_o && done_cyc == 0) done_cyc = cyc;
        wit_ready_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic compare_stream(input string name);
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL %s witness count: got %0d expected %0d", name, got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL %s witness[%0d]: got %h expected %h", name, i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; start_i = 1'b0; lo_i = 16'd0; hi_i = 16'd0;
        max_hits_i = 8'd0; wit_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        n_checks++;
        if ({cand_o, cand_valid_o, busy_o, done_o, hit_count_o, wit_valid_o} !== {16'd0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: got cand=%h cv=%b busy=%b done=%b hits=%0d wv=%b expected all zero",
                     cand_o, cand_valid_o, busy_o, done_o, hit_count_o, wit_valid_o);
        end
        rst_i = 1'b0;
    endtask

    task automatic test_stall_free(input bit restart_mid, input string name);
        int dc; bit to;
        sat_mode = 0; wit_ready_i = 1'b1; got_q.delete();
        build_expected(0, 15, 0);
        start_run(16'd0, 16'd15, 8'd0);
        n_checks++;
        if ({cand_valid_o, busy_o, cand_o} !== {1'b1, 1'b1, 16'd0}) begin
            n_fail++;
            $display("FAIL %s first cand: got cv=%b busy=%b cand=%h expected 1 1 0000", name, cand_valid_o, busy_o, cand_o);
        end
        if (restart_mid) begin
            repeat (4) begin @(posedge clk_i); #1; end
            lo_i = 16'd100; hi_i = 16'd200; max_hits_i = 8'd1; start_i = 1'b1;
            @(posedge clk_i); #1;
            start_i = 1'b0;
            wait_finish(6, 1'b0, dc, to);
        end else begin
            wait_finish(1, 1'b0, dc, to);
        end
        n_checks++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL %s timeout: got 1 expected 0", name); end
        n_checks++;
        if (dc !== 17) begin n_fail++; $display("FAIL %s done cycle: got %0d expected 17", name, dc); end
        n_checks++;
        if (hit_count_o !== 16'd4) begin n_fail++; $display("FAIL %s hit_count: got %0d expected 4", name, hit_count_o); end
        compare_stream(name);
    endtask

    task automatic test_hit_limit();
        int dc; bit to;
        sat_mode = 1; wit_ready_i = 1'b1; got_q.delete();
        build_expected(5, 9, 2);
        start_run(16'd5, 16'd9, 8'd2);
        wait_finish(1, 1'b0, dc, to);
        n_checks++;
        if ({to, dc} !== {1'b0, 32'd3}) begin n_fail++; $display("FAIL limit done cycle: got %0d (to=%b) expected 3", dc, to); end
        n_checks++;
        if ({cand_valid_o, cand_o} !== {1'b0, 16'd6}) begin
            n_fail++; $display("FAIL limit cand stop: got cv=%b cand=%h expected 0 0006", cand_valid_o, cand_o);
        end
        n_checks++;
        if (hit_count_o !== 16'd2) begin n_fail++; $display("FAIL limit hit_count: got %0d expected 2", hit_count_o); end
        compare_stream("limit");
    endtask

    task automatic test_back_pressure();
        int dc; bit to;
        sat_mode = 1; wit_ready_i = 1'b0; got_q.delete();
        build_expected(0, 7, 0);
        start_run(16'd0, 16'd7, 8'd0);
        for (int c = 1; c < 10; c++) begin
            @(posedge clk_i); #1;
        end
        n_checks++;
        if ({cand_o, cand_valid_o, wit_valid_o, busy_o} !== {16'd4, 1'b1, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL bp stall: got cand=%h cv=%b wv=%b busy=%b expected 0004 1 1 1", cand_o, cand_valid_o, wit_valid_o, busy_o);
        end
        n_checks++;
        if (hit_count_o !== 16'd4) begin n_fail++; $display("FAIL bp stall hits: got %0d expected 4", hit_count_o); end
        wit_ready_i = 1'b1;
        wait_finish(10, 1'b0, dc, to);
        n_checks++;
        if ({to, hit_count_o} !== {1'b0, 16'd8}) begin n_fail++; $display("FAIL bp hits: got %0d (to=%b) expected 8", hit_count_o, to); end
        compare_stream("bp");
    endtask

    task automatic test_boundaries();
        int dc; bit to;
        sat_mode = 1; wit_ready_i = 1'b1; got_q.delete();
        start_run(16'd3, 16'd2, 8'd0);
        n_checks++;
        if ({done_o, busy_o, cand_valid_o, hit_count_o} !== {1'b1, 1'b0, 1'b0, 16'd0}) begin
            n_fail++; $display("FAIL empty range: got done=%b busy=%b cv=%b hits=%0d expected 1 0 0 0", done_o, busy_o, cand_valid_o, hit_count_o);
        end
        repeat (2) @(posedge clk_i);
        #1;
        n_checks++;
        if (got_q.size() !== 0) begin n_fail++; $display("FAIL empty range witnesses: got %0d expected 0", got_q.size()); end
        build_expected(65535, 65535, 0);
        start_run(16'hFFFF, 16'hFFFF, 8'd0);
        wait_finish(1, 1'b0, dc, to);
        n_checks++;
        if ({to, dc, cand_o, cand_valid_o} !== {1'b0, 32'd2, 16'hFFFF, 1'b0}) begin
            n_fail++; $display("FAIL top bound: got dc=%0d cand=%h cv=%b to=%b expected 2 ffff 0 0", dc, cand_o, cand_valid_o, to);
        end
        n_checks++;
        if (hit_count_o !== 16'd1) begin n_fail++; $display("FAIL top bound hits: got %0d expected 1", hit_count_o); end
        compare_stream("top bound");
    endtask

    task automatic test_reset_mid_run();
        sat_mode = 1; wit_ready_i = 1'b0; got_q.delete();
        start_run(16'd5, 16'd9, 8'd0);
        repeat (2) begin @(posedge clk_i); #1; end
        n_checks++;
        if ({wit_valid_o, hit_count_o, busy_o} !== {1'b1, 16'd2, 1'b1}) begin
            n_fail++; $display("FAIL pre-reset: got wv=%b hits=%0d busy=%b expected 1 2 1", wit_valid_o, hit_count_o, busy_o);
        end
        rst_i = 1'b1; start_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0; start_i = 1'b0; wit_ready_i = 1'b1;
        n_checks++;
        if ({cand_o, cand_valid_o, busy_o, done_o, hit_count_o, wit_valid_o} !== {16'd0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0}) begin
            n_fail++; $display("FAIL mid reset: got cand=%h cv=%b busy=%b done=%b hits=%0d wv=%b expected all zero",
                               cand_o, cand_valid_o, busy_o, done_o, hit_count_o, wit_valid_o);
        end
        repeat (2) @(posedge clk_i);
        #1;
        n_checks++;
        if (got_q.size() !== 0) begin n_fail++; $display("FAIL mid reset drained: got %0d expected 0", got_q.size()); end
    endtask

    task automatic test_random();
        int dc; bit to; int lo, hi, mx;
        for (int it = 0; it < 6; it++) begin
            sat_mode = 2; seed = 16'($urandom); got_q.delete();
            lo = (it == 5) ? 65520 : int'($urandom_range(0, 65000));
            hi = (it == 5) ? 65535 : lo + int'($urandom_range(0, 40));
            mx = int'($urandom_range(0, 4));
            build_expected(lo, hi, mx);
            start_run(16'(lo), 16'(hi), 8'(mx));
            wait_finish(1, 1'b1, dc, to);
            n_checks++;
            if ({to, hit_count_o} !== {1'b0, 16'(exp_q.size())}) begin
                n_fail++; $display("FAIL random[%0d] hits: got %0d (to=%b) expected %0d", it, hit_count_o, to, exp_q.size());
            end
            compare_stream("random");
        end
    endtask

    initial begin
        test_reset();
        test_stall_free(1'b0, "stall-free");
        test_hit_limit();
        test_back_pressure();
        test_boundaries();
        test_reset_mid_run();
        test_stall_free(1'b1, "start-while-busy");
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
